// File: rtl/drain_counter_pkg.sv
// Shared types and defaults for the drain (consumer-side) counter.
// The drain counter walks i from a loaded bound y down to zero, never letting y reach x.
package counter_pkg;

   typedef enum logic {IDLE, DRAIN} state_t;

   localparam int W      = 15;
   localparam int X_INIT = 500;
   localparam int Y_INIT = 399;

   function automatic logic in_bounds(input logic [W-1:0] i,
                                      input logic [W-1:0] y,
                                      input logic [W-1:0] x);
      return (i <= y) && (y < x);
   endfunction

endpackage

// File: rtl/drain_counter_if.sv
// Control and status bundle between a drain counter and whoever drives it.
interface drain_counter_if #(parameter int W = 15) ();

   logic         selector;
   logic         load;
   logic [W-1:0] load_val;
   logic [W-1:0] i;
   logic [W-1:0] y;
   logic [W-1:0] x;
   logic         busy;
   logic         done;
   logic         err;

   modport master (
      output selector, load, load_val,
      input  i, y, x, busy, done, err
   );

   modport slave (
      input  selector, load, load_val,
      output i, y, x, busy, done, err
   );

endinterface

// File: rtl/drain_counter.sv
// Gated down-counter: loads a bound y (< x), decrements i to zero on selector,
// pulses done on reaching zero and latches err on rejected loads or broken invariants.
module drain_counter #(
   parameter int W      = counter_pkg::W,
   parameter int X_INIT = counter_pkg::X_INIT,
   parameter int Y_INIT = counter_pkg::Y_INIT
) (
   input logic           clk,
   input logic           rst,
   drain_counter_if.slave bus
);
   import counter_pkg::*;

   localparam state_t RST_STATE = (Y_INIT != 0) ? DRAIN : IDLE;

   state_t       state_reg, state_next;
   logic [W-1:0] i_reg, i_next;
   logic [W-1:0] y_reg, y_next;
   logic [W-1:0] x_reg;
   logic         busy_reg;
   logic         done_reg, done_next;
   logic         err_reg, err_next;
   logic         load_ok;

   assign load_ok = (bus.load_val < x_reg);

   always_comb begin
      state_next = state_reg;
      i_next     = i_reg;
      y_next     = y_reg;
      done_next  = 1'b0;
      err_next   = err_reg;

      // Invariant watch on the current registers; should never fire.
      if (!in_bounds(i_reg, y_reg, x_reg)) begin
         err_next = 1'b1;
      end

      if (bus.load) begin
         if (load_ok) begin
            i_next     = bus.load_val;
            y_next     = bus.load_val;
            state_next = (bus.load_val != '0) ? DRAIN : IDLE;
         end else begin
            err_next = 1'b1;
         end
      end else if (state_reg == DRAIN && bus.selector) begin
         if (i_reg > W'(1)) begin
            i_next = i_reg - W'(1);
         end else begin
            // Last step (or a degenerate zero): land on 0 and finish.
            i_next     = '0;
            state_next = IDLE;
            done_next  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= RST_STATE;
         i_reg     <= W'(Y_INIT);
         y_reg     <= W'(Y_INIT);
         x_reg     <= W'(X_INIT);
         busy_reg  <= (RST_STATE == DRAIN);
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         i_reg     <= i_next;
         y_reg     <= y_next;
         x_reg     <= x_reg;
         busy_reg  <= (state_next == DRAIN);
         done_reg  <= done_next;
         err_reg   <= err_next;
      end
   end

   assign bus.i    = i_reg;
   assign bus.y    = y_reg;
   assign bus.x    = x_reg;
   assign bus.busy = busy_reg;
   assign bus.done = done_reg;
   assign bus.err  = err_reg;

endmodule
